// File: rtl/keypad_pkg.sv
// Shared constants, PMOD KYPD key map and scan state type for the keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    // Indexed by col*4+row.
    localparam logic [3:0] KEY_MAP [NUM_KEYS] = '{
        4'h1, 4'h4, 4'h7, 4'h0,
        4'h2, 4'h5, 4'h8, 4'hF,
        4'h3, 4'h6, 4'h9, 4'hE,
        4'hA, 4'hB, 4'hC, 4'hD
    };

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK
    } scan_state_t;

    function automatic logic [3:0] lowest_index(input logic [NUM_KEYS-1:0] mask);
        logic [3:0] idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (mask[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Small synchronous FIFO for key codes; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module keypad_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Scans and debounces a 4x4 hex keypad and hands each new press out over valid/ready.
// Define KEYPAD_FIFO_EN to buffer presses in a FIFO_DEPTH-entry FIFO instead of one register.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1200,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_down,
    output logic       overrun
);

    // state | meaning
    // IDLE  | first cycle out of reset, no column driven
    // DRIVE | column col_q driven low for SCAN_DIV cycles, rows sampled on the last one
    // CHECK | full scan captured, debounce evaluated, no column driven

    localparam int DIV_W   = $clog2(SCAN_DIV);
    localparam int MATCH_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0]   DIV_LOAD  = DIV_W'(SCAN_DIV - 1);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(DEBOUNCE_SCANS);
    localparam bit PARAMS_OK = (SCAN_DIV >= 4) && (DEBOUNCE_SCANS >= 1) &&
                               (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

    if (!PARAMS_OK) begin : g_bad_params
        $error("keypad_scanner: SCAN_DIV/DEBOUNCE_SCANS/FIFO_DEPTH out of range");
    end

    scan_state_t         state_q, state_d;
    logic [1:0]          col_q, col_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [3:0]          row_meta_q, row_sync_q;
    logic [NUM_KEYS-1:0] raw_q, raw_d;
    logic [NUM_KEYS-1:0] last_raw_q, last_raw_d;
    logic [NUM_KEYS-1:0] stable_q, stable_d;
    logic [NUM_KEYS-1:0] pending_q, pending_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic                overrun_q, overrun_d;

    logic       emit_push;
    logic [3:0] emit_code;
    logic       buf_full;
    logic       buf_pop;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        div_d   = div_q;
        raw_d   = raw_q;
        col_n   = 4'b1111;
        case (state_q)
            IDLE: begin
                state_d = DRIVE;
                col_d   = '0;
                div_d   = DIV_LOAD;
            end
            DRIVE: begin
                col_n = ~(4'b0001 << col_q);
                if (div_q == '0) begin
                    raw_d[col_q*NUM_ROWS +: NUM_ROWS] = ~row_sync_q;
                    div_d = DIV_LOAD;
                    col_d = col_q + 2'd1;
                    if (col_q == 2'd3) state_d = CHECK;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            CHECK: begin
                state_d = DRIVE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pending presses drain one per cycle, well before the next CHECK can add more.
    always_comb begin
        last_raw_d = last_raw_q;
        match_d    = match_q;
        stable_d   = stable_q;
        pending_d  = pending_q;
        if (pending_q != '0) begin
            pending_d[lowest_index(pending_q)] = 1'b0;
        end
        if (state_q == CHECK) begin
            if (raw_q == last_raw_q) begin
                if (match_q != MATCH_MAX) match_d = match_q + 1'b1;
            end else begin
                match_d    = MATCH_W'(1);
                last_raw_d = raw_q;
            end
            if (match_d == MATCH_MAX && raw_q != stable_q) begin
                pending_d = pending_d | (raw_q & ~stable_q);
                stable_d  = raw_q;
            end
        end
    end

    assign emit_push = (pending_q != '0);
    assign emit_code = KEY_MAP[lowest_index(pending_q)];
    assign buf_pop   = key_valid & key_ready;
    assign overrun_d = overrun_q | (emit_push & buf_full & ~buf_pop);
    assign overrun   = overrun_q;
    assign key_down  = |stable_q;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            div_q      <= '0;
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            raw_q      <= '0;
            last_raw_q <= '0;
            stable_q   <= '0;
            pending_q  <= '0;
            match_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            div_q      <= div_d;
            row_meta_q <= row_n;
            row_sync_q <= row_meta_q;
            raw_q      <= raw_d;
            last_raw_q <= last_raw_d;
            stable_q   <= stable_d;
            pending_q  <= pending_d;
            match_q    <= match_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef KEYPAD_FIFO_EN
    logic fifo_empty;

    keypad_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .nreset    (nreset),
        .push      (emit_push),
        .push_data (emit_code),
        .full      (buf_full),
        .pop       (key_ready),
        .pop_data  (key_code),
        .empty     (fifo_empty)
    );

    assign key_valid = ~fifo_empty;
`else
    logic [3:0] code_q, code_d;
    logic       valid_q, valid_d;

    assign buf_full = valid_q;

    always_comb begin
        code_d  = code_q;
        valid_d = valid_q;
        if (buf_pop) valid_d = 1'b0;
        if (emit_push && (!buf_full || buf_pop)) begin
            code_d  = emit_code;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a keypad matrix model and a key-code scoreboard.
module tb_keypad_scanner;

    localparam int SCAN_DIV   = 8;
    localparam int DEB        = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int SCAN_CYC   = 4 * SCAN_DIV + 1;
    localparam int WAIT_LIMIT = 8 * SCAN_CYC;
`ifdef KEYPAD_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic        key_down;
    logic        overrun;
    logic [15:0] keys = '0;

    logic [3:0] code_tab [16] = '{4'h1, 4'h4, 4'h7, 4'h0, 4'h2, 4'h5, 4'h8, 4'hF,
                                  4'h3, 4'h6, 4'h9, 4'hE, 4'hA, 4'hB, 4'hC, 4'hD};
    int pp_idx [4] = '{1, 2, 3, 8};
    int ov_idx [4] = '{0, 5, 10, 15};

    logic [3:0] exp_q [$];
    int n_chk  = 0;
    int n_fail = 0;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB),
        .FIFO_DEPTH     (FIFO_DEPTH)
    ) dut (
        .clock     (clock),
        .nreset    (nreset),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_down  (key_down),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[c*4+r] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_down(input logic level, input string tag);
        int n = 0;
        while (key_down !== level && n < WAIT_LIMIT) begin
            @(negedge clock);
            n++;
        end
        check_eq({tag, "_key_down"}, 32'(key_down), 32'(level));
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (key_valid !== 1'b1 && n < WAIT_LIMIT) begin
            @(negedge clock);
            n++;
        end
        check_eq({tag, "_valid"}, 32'(key_valid), 32'd1);
    endtask

    task automatic pop_key(input string tag);
        wait_valid(tag);
        if (exp_q.size() == 0) check_eq({tag, "_unexpected"}, 32'(key_valid), 32'd0);
        else check_eq({tag, "_code"}, 32'(key_code), 32'(exp_q.pop_front()));
        key_ready = 1'b1;
        @(negedge clock);
        key_ready = 1'b0;
    endtask

    task automatic press_release(input int idx, input string tag);
        keys = 16'(1) << idx;
        wait_down(1'b1, {tag, "_press"});
        keys = '0;
        wait_down(1'b0, {tag, "_release"});
    endtask

    task automatic idle_scans(input int n);
        repeat (n * SCAN_CYC) @(negedge clock);
    endtask

    initial begin
        int n;

        // reset and release
        repeat (3) @(negedge clock);
        check_eq("rst_col_n", 32'(col_n), 32'hF);
        check_eq("rst_key_code", 32'(key_code), 32'h0);
        check_eq("rst_key_valid", 32'(key_valid), 32'd0);
        check_eq("rst_key_down", 32'(key_down), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        nreset = 1'b1;
        #1;
        check_eq("rel_col_n_now", 32'(col_n), 32'hF);
        repeat (2) @(posedge clock);
        #1;
        check_eq("rel_col_n_2cyc", 32'(col_n), 32'hE);
        @(negedge clock);

        // single press of key (1,2)
        keys = 16'(1) << 6;
        exp_q.push_back(code_tab[6]);
        wait_valid("t2");
        check_eq("t2_key_down", 32'(key_down), 32'd1);
        repeat (10) @(negedge clock);
        check_eq("t2_hold_valid", 32'(key_valid), 32'd1);
        check_eq("t2_hold_code", 32'(key_code), 32'h8);
        pop_key("t2");
        check_eq("t2_popped", 32'(key_valid), 32'd0);
        idle_scans(4);
        check_eq("t2_no_repeat", 32'(key_valid), 32'd0);
        keys = '0;
        wait_down(1'b0, "t6_release");
        idle_scans(2);
        check_eq("t6_no_code", 32'(key_valid), 32'd0);

        // bounce on key (0,0), then steady
        for (int i = 0; i < 6; i++) begin
            keys[0] = ~i[0];
            repeat (SCAN_CYC) @(negedge clock);
        end
        check_eq("t3_bounce_valid", 32'(key_valid), 32'd0);
        check_eq("t3_bounce_down", 32'(key_down), 32'd0);
        keys[0] = 1'b1;
        exp_q.push_back(code_tab[0]);
        pop_key("t3");
        idle_scans(3);
        check_eq("t3_single", 32'(key_valid), 32'd0);
        keys = '0;
        wait_down(1'b0, "t3_release");

`ifdef KEYPAD_FIFO_EN
        // simultaneous presses, lowest index first
        keys = (16'(1) << 15) | (16'(1) << 1);
        exp_q.push_back(code_tab[1]);
        exp_q.push_back(code_tab[15]);
        wait_down(1'b1, "t4");
        repeat (4) @(negedge clock);
        pop_key("t4_first");
        pop_key("t4_second");
        check_eq("t4_empty", 32'(key_valid), 32'd0);
        keys = '0;
        wait_down(1'b0, "t4_release");
`endif

        // pop and push in the same cycle with a full buffer
        for (int k = 0; k < CAP; k++) begin
            exp_q.push_back(code_tab[pp_idx[k]]);
            press_release(pp_idx[k], "t6_fill");
        end
        check_eq("t6_full_valid", 32'(key_valid), 32'd1);
        keys = 16'(1) << 9;
        wait_down(1'b1, "t6_pp");
        check_eq("t6_pp_head", 32'(key_code), 32'(exp_q.pop_front()));
        exp_q.push_back(code_tab[9]);
        key_ready = 1'b1;
        @(negedge clock);
        key_ready = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("t6_pp_overrun", 32'(overrun), 32'd0);
        keys = '0;
        wait_down(1'b0, "t6_pp_release");
        for (int k = 0; k < CAP; k++) pop_key("t6_drain");
        @(negedge clock);
        check_eq("t6_drained", 32'(key_valid), 32'd0);

        // overrun: one press more than the buffer holds
        for (int k = 0; k < CAP; k++) begin
            exp_q.push_back(code_tab[ov_idx[k]]);
            press_release(ov_idx[k], "t5_fill");
        end
        keys = 16'(1) << 4;
        wait_down(1'b1, "t5_extra");
        repeat (3) @(negedge clock);
        check_eq("t5_overrun", 32'(overrun), 32'd1);
        check_eq("t5_valid", 32'(key_valid), 32'd1);
        check_eq("t5_head", 32'(key_code), 32'(exp_q[0]));

        // reset mid-DRIVE with key (1,0) held
        n = 0;
        while (col_n == 4'hF && n < WAIT_LIMIT) begin
            @(negedge clock);
            n++;
        end
        check_eq("t1_mid_drive", 32'(col_n != 4'hF), 32'd1);
        nreset = 1'b0;
        #1;
        check_eq("t1_rst_col_n", 32'(col_n), 32'hF);
        check_eq("t1_rst_key_code", 32'(key_code), 32'h0);
        check_eq("t1_rst_key_valid", 32'(key_valid), 32'd0);
        check_eq("t1_rst_key_down", 32'(key_down), 32'd0);
        check_eq("t1_rst_overrun", 32'(overrun), 32'd0);
        exp_q.delete();
        @(negedge clock);
        nreset = 1'b1;
        exp_q.push_back(code_tab[4]);
        pop_key("t1_held_through_reset");
        check_eq("t1_overrun_after", 32'(overrun), 32'd0);
        keys = '0;
        wait_down(1'b0, "t1_release");
        idle_scans(1);
        check_eq("end_valid", 32'(key_valid), 32'd0);
        check_eq("end_scoreboard", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
